// File: rtl/onn_retrieval_scheduler_if.sv
// Request and result handshake bundle between the host/pattern feeder
// and the ONN retrieval scheduler.
interface onn_retrieval_scheduler_if #(
    parameter int TAG_W = 4,
    parameter int IW    = 8
);
    logic             req_valid;
    logic [TAG_W-1:0] req_tag;
    logic             req_ready;
    logic             done_valid;
    logic             done_ready;
    logic [TAG_W-1:0] done_tag;
    logic [1:0]       done_status;
    logic [IW-1:0]    done_iters;

    // Host side: issues requests, consumes results
    modport master (
        output req_valid, req_tag, done_ready,
        input  req_ready, done_valid, done_tag, done_status, done_iters
    );

    // Scheduler side
    modport slave (
        input  req_valid, req_tag, done_ready,
        output req_ready, done_valid, done_tag, done_status, done_iters
    );
endinterface

// File: rtl/onn_retrieval_scheduler.sv
// Retrieval run sequencer for the ONN core control FSM. Holds the core in
// reset between runs, strobes its load, counts settle iterations from the
// core's state-check rising edges and reports tag/status/iterations.
module onn_retrieval_scheduler #(
    parameter int N        = 210,
    parameter int MAX_ITER = 32,
    parameter int IW       = 8,
    parameter int TAG_W    = 4,
    parameter int WD_W     = 16,
    parameter int WD_CYC   = 4*N+64
) (
    input  logic                     sclk,
    input  logic                     re,
    onn_retrieval_scheduler_if.slave bus,
    input  logic                     abort,
    output logic                     core_re,
    output logic                     core_load,
    input  logic                     core_state_check,
    input  logic                     core_phi_to_no,
    output logic                     busy
);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_REPORT} state_t;

    localparam logic [IW-1:0]   ITER_LIM = IW'(MAX_ITER);
    localparam logic [WD_W-1:0] WD_LIM   = WD_W'(WD_CYC);

    localparam logic [1:0] ST_CONV  = 2'b00;
    localparam logic [1:0] ST_TMO   = 2'b01;
    localparam logic [1:0] ST_STALL = 2'b10;
    localparam logic [1:0] ST_ABORT = 2'b11;

    state_t           state_q;
    logic             req_ready_q;
    logic             core_re_q;
    logic             core_load_q;
    logic             busy_q;
    logic             done_valid_q;
    logic [TAG_W-1:0] done_tag_q;
    logic [1:0]       done_status_q;
    logic [IW-1:0]    done_iters_q;
    logic [TAG_W-1:0] tag_q;
    logic [IW-1:0]    iter_q;
    logic [IW-1:0]    iter_d;
    logic [WD_W-1:0]  wd_q;
    logic [WD_W-1:0]  wd_d;
    logic             sc_prev_q;
    logic             sc_rise;
    logic             run_exit;

    function automatic logic [IW-1:0] sat_inc_iter(input logic [IW-1:0] v);
        return (&v) ? v : v + IW'(1);
    endfunction

    function automatic logic [WD_W-1:0] sat_inc_wd(input logic [WD_W-1:0] v);
        return (&v) ? v : v + WD_W'(1);
    endfunction

    // Exit cause in priority order: abort, convergence, iteration limit, stall
    function automatic logic [1:0] exit_status(input logic ab, input logic conv,
                                               input logic lim);
        if (ab)        return ST_ABORT;
        else if (conv) return ST_CONV;
        else if (lim)  return ST_TMO;
        else           return ST_STALL;
    endfunction

    // Per-cycle iteration/watchdog update seen by the RUN exit decision
    always_comb begin
        sc_rise  = core_state_check & ~sc_prev_q;
        iter_d   = sc_rise ? sat_inc_iter(iter_q) : iter_q;
        wd_d     = sc_rise ? '0 : sat_inc_wd(wd_q);
        run_exit = abort | core_phi_to_no | (iter_d == ITER_LIM) | (wd_d == WD_LIM);
    end

    // Run sequencer with registered core controls and result fields
    always_ff @(posedge sclk or posedge re) begin
        if (re) begin
            state_q       <= S_IDLE;
            req_ready_q   <= 1'b1;
            core_re_q     <= 1'b1;
            core_load_q   <= 1'b0;
            busy_q        <= 1'b0;
            done_valid_q  <= 1'b0;
            done_tag_q    <= '0;
            done_status_q <= 2'b00;
            done_iters_q  <= '0;
            tag_q         <= '0;
            iter_q        <= '0;
            wd_q          <= '0;
            sc_prev_q     <= 1'b0;
        end else begin
            sc_prev_q <= core_state_check;
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid && req_ready_q) begin
                        tag_q       <= bus.req_tag;
                        iter_q      <= '0;
                        wd_q        <= '0;
                        // A stale level from the previous run must not look like an edge
                        sc_prev_q   <= 1'b0;
                        req_ready_q <= 1'b0;
                        core_re_q   <= 1'b0;
                        core_load_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    core_load_q <= 1'b0;
                    state_q     <= S_RUN;
                end
                S_RUN: begin
                    iter_q <= iter_d;
                    wd_q   <= wd_d;
                    if (run_exit) begin
                        done_status_q <= exit_status(abort, core_phi_to_no,
                                                     iter_d == ITER_LIM);
                        done_tag_q    <= tag_q;
                        done_iters_q  <= iter_d;
                        done_valid_q  <= 1'b1;
                        core_re_q     <= 1'b1;
                        busy_q        <= 1'b0;
                        state_q       <= S_REPORT;
                    end
                end
                S_REPORT: begin
                    if (done_valid_q && bus.done_ready) begin
                        done_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.req_ready   = req_ready_q;
    assign bus.done_valid  = done_valid_q;
    assign bus.done_tag    = done_tag_q;
    assign bus.done_status = done_status_q;
    assign bus.done_iters  = done_iters_q;
    assign core_re         = core_re_q;
    assign core_load       = core_load_q;
    assign busy            = busy_q;
endmodule

// File: tb/tb_onn_retrieval_scheduler.sv
// Bench for onn_retrieval_scheduler: table-driven runs, hand sequences for
// reset behaviour, and randomized runs checked against a trace-level model.
module tb_onn_retrieval_scheduler;
    localparam int MAXI = 4;
    localparam int WDC  = 900;

    logic sclk;
    logic re;
    logic abort;
    logic core_state_check;
    logic core_phi_to_no;
    logic core_re;
    logic core_load;
    logic busy;

    onn_retrieval_scheduler_if #(.TAG_W(4), .IW(8)) bus ();

    onn_retrieval_scheduler #(
        .N(210), .MAX_ITER(MAXI), .IW(8), .TAG_W(4), .WD_W(16), .WD_CYC(WDC)
    ) dut (
        .sclk             (sclk),
        .re               (re),
        .bus              (bus),
        .abort            (abort),
        .core_re          (core_re),
        .core_load        (core_load),
        .core_state_check (core_state_check),
        .core_phi_to_no   (core_phi_to_no),
        .busy             (busy)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_vec = 0;
    int n_bad = 0;

    // Per-RUN-cycle stimulus traces, index 0 = first RUN cycle
    logic [1023:0] sc_v;
    logic [1023:0] phi_v;
    logic [1023:0] ab_v;

    typedef struct {
        int tag;
        int n_edges;
        int period;
        int phi_cyc;
        int ab_cyc;
        int hold;
        int exp_st;
        int exp_it;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Build traces: state_check high for 2 cycles per edge, phi high from
    // phi_cyc onward, abort a one-cycle pulse.
    task automatic fill_vec(input vec_t v);
        sc_v = '0; phi_v = '0; ab_v = '0;
        for (int i = 0; i < v.n_edges; i++) begin
            sc_v[3 + i*v.period]     = 1'b1;
            sc_v[3 + i*v.period + 1] = 1'b1;
        end
        if (v.phi_cyc >= 0)
            for (int t = v.phi_cyc; t < 1024; t++) phi_v[t] = 1'b1;
        if (v.ab_cyc >= 0) ab_v[v.ab_cyc] = 1'b1;
    endtask

    // Trace-level reference: scan the RUN trace for the first cycle where an
    // end condition holds, counting rising edges and cycles since the last one.
    task automatic model(output int ex, output int st, output int it);
        int rises;
        int last;
        int idle;
        bit rose;
        bit stop;
        rises = 0; last = -1; ex = -1; st = 0; it = 0; stop = 1'b0;
        for (int t = 0; t < 1024 && !stop; t++) begin
            if (t == 0) rose = sc_v[0];
            else        rose = sc_v[t] && !sc_v[t-1];
            if (rose) begin rises++; last = t; end
            idle = (last < 0) ? t + 1 : t - last;
            stop = 1'b1;
            if (ab_v[t])              st = 3;
            else if (phi_v[t])        st = 0;
            else if (rises == MAXI)   st = 1;
            else if (idle == WDC)     st = 2;
            else                      stop = 1'b0;
            if (stop) begin ex = t; it = rises; end
        end
    endtask

    // One full run; entered and left at posedge+1 of an IDLE cycle
    task automatic run_one(input int tag, input int exp_ex, input int exp_st,
                           input int exp_it, input int hold,
                           input bit ab_idle, input bit ab_load, input bit ab_rep);
        int ex;
        chk("idle_req_ready", int'(bus.req_ready), 1);
        chk("idle_core_re", int'(core_re), 1);
        bus.req_valid = 1'b1;
        bus.req_tag   = 4'(tag);
        abort         = ab_idle;
        @(posedge sclk); #1;
        bus.req_valid = 1'b0;
        abort         = ab_load;
        chk("load_core_load", int'(core_load), 1);
        chk("load_core_re", int'(core_re), 0);
        chk("load_busy", int'(busy), 1);
        chk("load_req_ready", int'(bus.req_ready), 0);
        @(posedge sclk); #1;
        chk("run_core_load", int'(core_load), 0);
        ex = -1;
        for (int t = 0; t < 1000; t++) begin
            core_state_check = sc_v[t];
            core_phi_to_no   = phi_v[t];
            abort            = ab_v[t];
            @(posedge sclk); #1;
            if (bus.done_valid) begin ex = t; break; end
        end
        core_state_check = 1'b0;
        core_phi_to_no   = 1'b0;
        abort            = ab_rep;
        chk("exit_cycle", ex, exp_ex);
        chk("done_tag", int'(bus.done_tag), tag);
        chk("done_status", int'(bus.done_status), exp_st);
        chk("done_iters", int'(bus.done_iters), exp_it);
        chk("report_busy", int'(busy), 0);
        chk("report_core_re", int'(core_re), 1);
        for (int h = 0; h < hold; h++) begin
            @(posedge sclk); #1;
            abort = 1'b0;
            chk("hold_done_valid", int'(bus.done_valid), 1);
            chk("hold_done_tag", int'(bus.done_tag), tag);
            chk("hold_done_status", int'(bus.done_status), exp_st);
            chk("hold_done_iters", int'(bus.done_iters), exp_it);
            chk("hold_req_ready", int'(bus.req_ready), 0);
            chk("hold_core_re", int'(core_re), 1);
        end
        bus.done_ready = 1'b1;
        @(posedge sclk); #1;
        bus.done_ready = 1'b0;
        abort          = 1'b0;
        chk("post_done_valid", int'(bus.done_valid), 0);
        chk("post_req_ready", int'(bus.req_ready), 1);
        chk("post_core_re", int'(core_re), 1);
    endtask

    task automatic check_reset_vals(input string tagname);
        chk({tagname, "_req_ready"}, int'(bus.req_ready), 1);
        chk({tagname, "_core_re"}, int'(core_re), 1);
        chk({tagname, "_core_load"}, int'(core_load), 0);
        chk({tagname, "_busy"}, int'(busy), 0);
        chk({tagname, "_done_valid"}, int'(bus.done_valid), 0);
        chk({tagname, "_done_tag"}, int'(bus.done_tag), 0);
        chk({tagname, "_done_status"}, int'(bus.done_status), 0);
        chk({tagname, "_done_iters"}, int'(bus.done_iters), 0);
    endtask

    task automatic apply_vec(input vec_t v);
        int ex, st, it;
        fill_vec(v);
        model(ex, st, it);
        run_one(v.tag, ex, v.exp_st, v.exp_it, v.hold, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #900000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ex, st, it;
        int pc;
        //              tag edges per phi  abort hold st it
        vecs[0] = '{5,  3, 6, 20, -1, 10, 0, 3};  // converge after 3 iterations
        vecs[1] = '{9,  6, 5, -1, -1,  1, 1, 4};  // iteration limit
        vecs[2] = '{2,  0, 5, -1, -1,  0, 2, 0};  // stall, no edges
        vecs[3] = '{7,  4, 5, 18, -1,  2, 0, 4};  // limit and convergence together
        vecs[4] = '{3,  4, 5, 18, 18,  0, 3, 4};  // abort beats everything
        vecs[5] = '{12, 2, 5, -1, 10,  1, 3, 2};  // abort mid-run
        vecs[6] = '{15, 0, 5,  0, -1,  0, 0, 0};  // converged in first RUN cycle
        vecs[7] = '{1,  1, 5, -1, -1,  0, 2, 1};  // watchdog restarts on edge

        re = 1'b1;
        abort = 1'b0;
        core_state_check = 1'b0;
        core_phi_to_no = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_tag = '0;
        bus.done_ready = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        check_reset_vals("rst");
        re = 1'b0;
        @(posedge sclk); #1;

        for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

        // abort while not running must be ignored
        fill_vec(vecs[0]);
        model(ex, st, it);
        run_one(11, ex, 0, 3, 1, 1'b1, 1'b1, 1'b1);

        // randomized runs
        for (int r = 0; r < 20; r++) begin
            sc_v = '0; phi_v = '0; ab_v = '0;
            if ($urandom_range(0, 4) != 0) begin
                for (int t = 2; t < 1024; t++) sc_v[t] = ($urandom_range(0, 3) == 0);
                if ($urandom_range(0, 2) == 0) begin
                    pc = $urandom_range(0, 30);
                    for (int t = pc; t < 1024; t++) phi_v[t] = 1'b1;
                end
                if ($urandom_range(0, 3) == 0) ab_v[$urandom_range(0, 30)] = 1'b1;
            end
            model(ex, st, it);
            run_one(int'($urandom_range(0, 15)), ex, st, it, int'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end

        // asynchronous reset in the middle of a run
        bus.req_valid = 1'b1;
        bus.req_tag = 4'd6;
        @(posedge sclk); #1;
        bus.req_valid = 1'b0;
        @(posedge sclk); #1;
        core_state_check = 1'b1;
        @(posedge sclk); #1;
        core_state_check = 1'b0;
        @(posedge sclk); #1;
        chk("midrun_busy", int'(busy), 1);
        #2 re = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(posedge sclk); #1;
        chk("async_rst_hold_done_valid", int'(bus.done_valid), 0);
        re = 1'b0;
        @(posedge sclk); #1;
        chk("after_rst_done_valid", int'(bus.done_valid), 0);
        apply_vec(vecs[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
